// File: rtl/tree_pkg.sv
// Shared types and helpers for the tree-node gather path: default widths,
// the tagged queue entry, and the round-robin pointer increment.
package tree_pkg;

   localparam int N_CHILD = 5;
   localparam int DATA_W  = 8;
   localparam int IDX_W   = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } gather_entry_t;

   // Advance a child pointer, wrapping back to 0 after the last child.
   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr);
      if (int'(ptr) >= N_CHILD - 1)
         return '0;
      else
         return ptr + 1'b1;
   endfunction

endpackage

// File: rtl/tree_gather_fifo2.sv
// Two-entry FIFO of tagged gather entries; slot 0 is always the head so the
// parent sees a registered word that holds steady until it is popped.
module tree_gather_fifo2
   import tree_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  gather_entry_t din,
   input  logic          pop,
   output gather_entry_t head,
   output logic [1:0]    count
);

   gather_entry_t slot0;
   gather_entry_t slot1;

   assign head = slot0;

   // Writes land in the first free slot after the pop (if any) is accounted for.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0)
                  slot0 <= din;
               else
                  slot1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  slot0 <= slot1;
                  slot1 <= din;
               end else begin
                  slot0 <= din;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/tree_node_gather.sv
// Fan-in collector for one tree node: round-robin arbitration over the child
// streams, tagging each accepted word with its child index into a 2-deep queue.
module tree_node_gather
   import tree_pkg::*;
#(
   parameter int DATA_W  = tree_pkg::DATA_W,
   parameter int N_CHILD = tree_pkg::N_CHILD,
   parameter int IDX_W   = tree_pkg::IDX_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_CHILD-1:0]        child_valid,
   input  logic [N_CHILD*DATA_W-1:0] child_data,
   output logic [N_CHILD-1:0]        child_ready,
   output logic                      par_valid,
   output logic [DATA_W-1:0]         par_data,
   output logic [IDX_W-1:0]          par_idx,
   input  logic                      par_ready,
   output logic [15:0]               accept_cnt
);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] cand;
   logic             found;
   logic             space;
   logic             grant;
   logic             pop;
   logic [1:0]       count;
   gather_entry_t    push_entry;
   gather_entry_t    head;

   // Scan children starting at the pointer; the first valid one wins.
   always_comb begin
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N_CHILD; k++) begin
         int j;
         j = int'(rr_ptr) + k;
         if (j >= N_CHILD)
            j = j - N_CHILD;
         if (!found && child_valid[j]) begin
            found = 1'b1;
            cand  = IDX_W'(j);
         end
      end
   end

   // A pop in the same cycle frees a slot, so a full queue can still take a word.
   assign space      = (count < 2'd2) || (count == 2'd2 && par_ready);
   assign grant      = found && space && !rst;
   assign child_ready = grant ? (N_CHILD'(1) << cand) : '0;
   assign pop        = par_valid && par_ready;

   assign push_entry.idx  = cand;
   assign push_entry.data = child_data[cand*DATA_W +: DATA_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr     <= '0;
         accept_cnt <= 16'd0;
      end else if (grant) begin
         rr_ptr     <= rr_next(cand);
         accept_cnt <= accept_cnt + 16'd1;
      end
   end

   tree_gather_fifo2 u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (grant),
      .din   (push_entry),
      .pop   (pop),
      .head  (head),
      .count (count)
   );

   assign par_valid = (count != 2'd0);
   assign par_data  = head.data;
   assign par_idx   = head.idx;

endmodule
